// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the blockram port between the CPU load/store path and the VGA/debug reader
// Optional build macro: DMEM_ARB_RR_EN (round-robin arbitration instead of CPU priority with starvation override)
module dmem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1,
  parameter int STARVE_MAX  = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [3:0]        cpu_be,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_ack,
  output logic [DATA_W-1:0] vga_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [2:0] LAT_LAST = 3'(MEM_LATENCY - 1);

  state_t     state;
  logic [2:0] lat_cnt;
  logic       grant_vga;
  logic       acc_we;
  logic       sel_vga;

`ifdef DMEM_ARB_RR_EN
  // Set when the CPU won the previous grant, so VGA goes first on a tie.
  logic rr_vga;
  always_comb sel_vga = vga_req && (!cpu_req || rr_vga);
`else
  logic [7:0] starve_cnt;
  always_comb sel_vga = vga_req && (!cpu_req || (starve_cnt == 8'(STARVE_MAX)));
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      grant_vga <= 1'b0;
      acc_we    <= 1'b0;
      cpu_ack   <= 1'b0;
      vga_ack   <= 1'b0;
      cpu_rdata <= '0;
      vga_rdata <= '0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      rr_vga    <= 1'b0;
`else
      starve_cnt <= '0;
`endif
    end else begin
      cpu_ack <= 1'b0;
      vga_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req || vga_req) begin
            state     <= ACCESS;
            lat_cnt   <= '0;
            grant_vga <= sel_vga;
            mem_addr  <= sel_vga ? vga_addr : cpu_addr;
            mem_wdata <= sel_vga ? '0 : cpu_wdata;
            mem_be    <= sel_vga ? 4'hF : cpu_be;
            mem_we    <= !sel_vga && cpu_we;
            acc_we    <= !sel_vga && cpu_we;
`ifdef DMEM_ARB_RR_EN
            rr_vga    <= !sel_vga;
`else
            if (sel_vga) begin
              starve_cnt <= '0;
            end else if (vga_req && (starve_cnt != 8'(STARVE_MAX))) begin
              starve_cnt <= starve_cnt + 8'd1;
            end
`endif
          end
        end
        ACCESS: begin
          // The write strobe is a single cycle; address and data stay put until RESP.
          mem_we  <= 1'b0;
          lat_cnt <= lat_cnt + 3'd1;
          if (lat_cnt == LAT_LAST) begin
            state  <= RESP;
            mem_be <= '0;
            if (grant_vga) begin
              vga_rdata <= mem_rdata;
              vga_ack   <= 1'b1;
            end else begin
              cpu_ack <= 1'b1;
              if (!acc_we) begin
                cpu_rdata <= mem_rdata;
              end
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter at memory latency 1 and 3
module tb_dmem_arbiter;

  localparam int SM = 3;
`ifdef DMEM_ARB_RR_EN
  localparam logic [4:0] EXP_ORD = 5'b01010;
`else
  localparam logic [4:0] EXP_ORD = 5'b01000;
`endif

  logic        clk     = 1'b0;
  logic        resetn  = 1'b0;
  logic        mem_clr = 1'b1;

  logic        cpu_req   [2];
  logic        cpu_we    [2];
  logic [3:0]  cpu_be    [2];
  logic [31:0] cpu_addr  [2];
  logic [31:0] cpu_wdata [2];
  logic        cpu_ack   [2];
  logic [31:0] cpu_rdata [2];
  logic        vga_req   [2];
  logic [31:0] vga_addr  [2];
  logic        vga_ack   [2];
  logic [31:0] vga_rdata [2];
  logic [31:0] mem_addr  [2];
  logic [3:0]  mem_be    [2];
  logic [31:0] mem_wdata [2];
  logic        mem_we    [2];
  logic [31:0] mem_rdata [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_MAX(SM)) u_dut0 (
    .clk(clk), .resetn(resetn),
    .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_be(cpu_be[0]), .cpu_addr(cpu_addr[0]),
    .cpu_wdata(cpu_wdata[0]), .cpu_ack(cpu_ack[0]), .cpu_rdata(cpu_rdata[0]),
    .vga_req(vga_req[0]), .vga_addr(vga_addr[0]), .vga_ack(vga_ack[0]), .vga_rdata(vga_rdata[0]),
    .mem_addr(mem_addr[0]), .mem_be(mem_be[0]), .mem_wdata(mem_wdata[0]), .mem_we(mem_we[0]),
    .mem_rdata(mem_rdata[0])
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .STARVE_MAX(SM)) u_dut1 (
    .clk(clk), .resetn(resetn),
    .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_be(cpu_be[1]), .cpu_addr(cpu_addr[1]),
    .cpu_wdata(cpu_wdata[1]), .cpu_ack(cpu_ack[1]), .cpu_rdata(cpu_rdata[1]),
    .vga_req(vga_req[1]), .vga_addr(vga_addr[1]), .vga_ack(vga_ack[1]), .vga_rdata(vga_rdata[1]),
    .mem_addr(mem_addr[1]), .mem_be(mem_be[1]), .mem_wdata(mem_wdata[1]), .mem_we(mem_we[1]),
    .mem_rdata(mem_rdata[1])
  );

  // Blockram stand-in: byte-masked writes, read data follows the held address.
  logic [31:0] bmem [2][256];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_clr) begin
        for (int k = 0; k < 256; k++) bmem[i][k] <= '0;
      end else if (mem_we[i]) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[i][b]) bmem[i][mem_addr[i][9:2]][8*b +: 8] <= mem_wdata[i][8*b +: 8];
      end
    end
  end
  assign mem_rdata[0] = bmem[0][mem_addr[0][9:2]];
  assign mem_rdata[1] = bmem[1][mem_addr[1][9:2]];

  // Transaction-level reference: one access occupies cycles g..g+L-1, acks at g+L.
  int          ecnt = 0;
  bit          act    [2];
  bit          t_vga  [2];
  bit          t_we   [2];
  logic [3:0]  t_be   [2];
  logic [31:0] t_addr [2];
  logic [31:0] t_wdata[2];
  int          t_g    [2];
  int          starve [2];
  bit          rr_vga [2];
  logic [31:0] mm     [2][256];
  logic [31:0] x_cpu_rd [2];
  logic [31:0] x_vga_rd [2];
  bit          grant_log [$];
  int          we_cnt [2];
  int          be_cnt [2];

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic model_step(input int i);
    int  L = lat_of(i);
    bit  sv;
    if (mem_clr) for (int k = 0; k < 256; k++) mm[i][k] = '0;
    if (!resetn) begin
      act[i] = 0; starve[i] = 0; rr_vga[i] = 0; x_cpu_rd[i] = '0; x_vga_rd[i] = '0;
      return;
    end
    if (act[i] && t_we[i] && ecnt == t_g[i] + 1)
      for (int b = 0; b < 4; b++)
        if (t_be[i][b]) mm[i][t_addr[i][9:2]][8*b +: 8] = t_wdata[i][8*b +: 8];
    if (act[i] && !t_we[i] && ecnt == t_g[i] + L) begin
      if (t_vga[i]) x_vga_rd[i] = mm[i][t_addr[i][9:2]];
      else          x_cpu_rd[i] = mm[i][t_addr[i][9:2]];
    end
    if (!act[i] || ecnt >= t_g[i] + L + 2) begin
      if (cpu_req[i] || vga_req[i]) begin
`ifdef DMEM_ARB_RR_EN
        sv = vga_req[i] && (!cpu_req[i] || rr_vga[i]);
        rr_vga[i] = !sv;
`else
        sv = vga_req[i] && (!cpu_req[i] || starve[i] == SM);
        if (sv) starve[i] = 0;
        else if (vga_req[i] && starve[i] < SM) starve[i]++;
`endif
        act[i] = 1; t_vga[i] = sv; t_we[i] = !sv && cpu_we[i];
        t_be[i]    = sv ? 4'hF : cpu_be[i];
        t_addr[i]  = sv ? vga_addr[i] : cpu_addr[i];
        t_wdata[i] = cpu_wdata[i];
        t_g[i]     = ecnt;
        if (i == 0) grant_log.push_back(sv);
      end else begin
        act[i] = 0;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      ecnt++;
      for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  task automatic chk(input int i, input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL dut%0d %s: got 0x%0h, expected 0x%0h (cycle %0d)", i, name, got, exp, ecnt);
    end
  endtask

  task automatic compare(input int i);
    int L = lat_of(i);
    bit in_acc, in_resp;
    in_acc  = act[i] && ecnt >= t_g[i] && ecnt <= t_g[i] + L - 1;
    in_resp = act[i] && ecnt == t_g[i] + L;
    chk(i, "cpu_ack", cpu_ack[i], in_resp && !t_vga[i]);
    chk(i, "vga_ack", vga_ack[i], in_resp && t_vga[i]);
    chk(i, "mem_we", mem_we[i], in_acc && t_we[i] && ecnt == t_g[i]);
    chk(i, "mem_be", mem_be[i], in_acc ? t_be[i] : 4'h0);
    if (in_acc) begin
      chk(i, "mem_addr", mem_addr[i], t_addr[i]);
      if (!t_vga[i]) chk(i, "mem_wdata", mem_wdata[i], t_wdata[i]);
    end
    chk(i, "cpu_rdata", cpu_rdata[i], x_cpu_rd[i]);
    chk(i, "vga_rdata", vga_rdata[i], x_vga_rd[i]);
    if (mem_we[i]) we_cnt[i]++;
    if (mem_be[i] != 4'h0) be_cnt[i]++;
  endtask

  task automatic tick();
    @(negedge clk);
    if (resetn) begin
      compare(0);
      compare(1);
    end
  endtask

  task automatic cpu_access(input int i, input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wdata, output int lat);
    cpu_req[i] = 1'b1; cpu_we[i] = we; cpu_be[i] = be; cpu_addr[i] = addr; cpu_wdata[i] = wdata;
    lat = -1;
    for (int n = 1; n <= 20 && lat < 0; n++) begin
      tick();
      if (cpu_ack[i]) lat = n;
    end
    cpu_req[i] = 1'b0;
    if (lat < 0) chk(i, "cpu_ack_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic vga_access(input int i, input logic [31:0] addr, output int lat);
    vga_req[i] = 1'b1; vga_addr[i] = addr;
    lat = -1;
    for (int n = 1; n <= 20 && lat < 0; n++) begin
      tick();
      if (vga_ack[i]) lat = n;
    end
    vga_req[i] = 1'b0;
    if (lat < 0) chk(i, "vga_ack_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic btb(input int i, input int gap);
    logic [31:0] wv [3];
    int cyc [3];
    int k, lat;
    wv = '{32'hA5A5_0001, 32'h5A5A_0002, 32'h0F0F_0003};
    for (int j = 0; j < 3; j++) cpu_access(i, 1'b1, 4'hF, 32'h200 + 32'(4*j), wv[j], lat);
    k = 0;
    cpu_req[i] = 1'b1; cpu_we[i] = 1'b0; cpu_be[i] = 4'hF; cpu_addr[i] = 32'h200;
    for (int n = 0; n < 60 && k < 3; n++) begin
      tick();
      if (cpu_ack[i]) begin
        cyc[k] = ecnt;
        chk(i, "btb_rdata", cpu_rdata[i], wv[k]);
        k++;
        if (k < 3) cpu_addr[i] = 32'h200 + 32'(4*k);
        else       cpu_req[i] = 1'b0;
      end
    end
    cpu_req[i] = 1'b0;
    chk(i, "btb_ack_count", k, 3);
    if (k == 3) begin
      chk(i, "btb_gap1", cyc[1] - cyc[0], gap);
      chk(i, "btb_gap2", cyc[2] - cyc[1], gap);
    end
    tick();
  endtask

  initial begin
    int lat, snap, base, nack;
    logic [4:0] ord, mord;
    for (int i = 0; i < 2; i++) begin
      cpu_req[i] = 0; cpu_we[i] = 0; cpu_be[i] = '0; cpu_addr[i] = '0; cpu_wdata[i] = '0;
      vga_req[i] = 0; vga_addr[i] = '0; we_cnt[i] = 0; be_cnt[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk(0, "rst_cpu_ack", cpu_ack[0], 0);
    chk(0, "rst_mem_we", mem_we[0], 0);
    chk(0, "rst_mem_addr", mem_addr[0], 0);
    chk(1, "rst_mem_be", mem_be[1], 0);
    chk(1, "rst_vga_rdata", vga_rdata[1], 0);
    mem_clr = 1'b0;
    resetn  = 1'b1;
    tick();

    snap = we_cnt[0];
    cpu_access(0, 1'b1, 4'b0011, 32'h40, 32'hDEADBEEF, lat);
    chk(0, "wr_latency", lat, 2);
    chk(0, "wr_we_cycles", we_cnt[0] - snap, 1);
    cpu_access(0, 1'b0, 4'hF, 32'h40, 32'h0, lat);
    chk(0, "rd_latency", lat, 2);
    chk(0, "rd_rdata", cpu_rdata[0], 32'h0000BEEF);

    cpu_access(0, 1'b1, 4'hF, 32'h100, 32'h12345678, lat);
    snap = we_cnt[0];
    vga_access(0, 32'h100, lat);
    chk(0, "vga_latency", lat, 2);
    chk(0, "vga_rdata", vga_rdata[0], 32'h12345678);
    chk(0, "vga_no_write", we_cnt[0] - snap, 0);
    repeat (3) tick();
    chk(0, "vga_rdata_held", vga_rdata[0], 32'h12345678);

    base = grant_log.size();
    nack = 0; ord = '0; mord = '0;
    cpu_req[0] = 1; cpu_we[0] = 0; cpu_be[0] = 4'hF; cpu_addr[0] = 32'h40;
    vga_req[0] = 1; vga_addr[0] = 32'h100;
    for (int n = 0; n < 100 && nack < 5; n++) begin
      tick();
      if (cpu_ack[0] || vga_ack[0]) begin
        ord[nack] = vga_ack[0];
        nack++;
      end
    end
    cpu_req[0] = 0; vga_req[0] = 0;
    for (int k = 0; k < 5; k++) if (base + k < grant_log.size()) mord[k] = grant_log[base + k];
    chk(0, "cont_ack_count", nack, 5);
    chk(0, "cont_order_dut", ord, EXP_ORD);
    chk(0, "cont_order_model", mord, EXP_ORD);
    repeat (2) tick();

    cpu_access(1, 1'b1, 4'hF, 32'h80, 32'hCAFEF00D, lat);
    chk(1, "l3_wr_latency", lat, 4);
    snap = be_cnt[1];
    cpu_access(1, 1'b0, 4'hF, 32'h80, 32'h0, lat);
    chk(1, "l3_rd_latency", lat, 4);
    chk(1, "l3_rd_rdata", cpu_rdata[1], 32'hCAFEF00D);
    chk(1, "l3_access_cycles", be_cnt[1] - snap, 3);

    btb(0, 3);
    btb(1, 5);

    cpu_req[0] = 1; cpu_we[0] = 1; cpu_be[0] = 4'hF; cpu_addr[0] = 32'h300; cpu_wdata[0] = 32'h55AA55AA;
    @(posedge clk);
    #2;
    chk(0, "rst_pre_we", mem_we[0], 1);
    resetn = 1'b0;
    #1;
    chk(0, "arst_mem_we", mem_we[0], 0);
    chk(0, "arst_mem_addr", mem_addr[0], 0);
    chk(0, "arst_mem_be", mem_be[0], 0);
    chk(0, "arst_mem_wdata", mem_wdata[0], 0);
    chk(0, "arst_cpu_ack", cpu_ack[0], 0);
    chk(0, "arst_cpu_rdata", cpu_rdata[0], 0);
    chk(0, "arst_vga_rdata", vga_rdata[0], 0);
    cpu_req[0] = 0;
    repeat (3) tick();
    chk(0, "arst_no_ack", cpu_ack[0], 0);
    resetn = 1'b1;
    tick();
    cpu_access(0, 1'b0, 4'hF, 32'h300, 32'h0, lat);
    chk(0, "post_rst_latency", lat, 2);
    chk(0, "post_rst_rdata", cpu_rdata[0], 32'h0);
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

endmodule
